de2_115_sopc_st_packet_arbiter: RTL and testbench

Two-input Avalon-ST packet arbiter that shares one downstream stream between two requesters, typically in front of the timing adapter's FIFO.
Arbitration is packet-granular round-robin. A grant is held from the first accepted beat until the beat carrying endofpacket is accepted, so packets never interleave.
The output is registered with one pipeline stage, and an out_channel sideband identifies the source.

---
 rtl/de2_115_sopc_st_packet_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_de2_115_sopc_st_packet_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_sopc_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// de2_115_sopc_st_packet_arbiter
//
// Two-input Avalon-ST packet arbiter sharing one downstream stream. Arbitration
// is round-robin at packet granularity: once the first beat of a packet is
// accepted the grant is held until its endofpacket beat is accepted, so packets
// never interleave. The output is a single registered pipeline stage with an
// out_channel sideband naming the source input.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   inN_ready (out)         input N may transfer this cycle (ready latency 0)
//   inN_valid/data/error/startofpacket/endofpacket/empty (in)   sink N
//   out_ready (in)          downstream ready
//   out_valid/data/error/startofpacket/endofpacket/empty (out)  registered source
//   out_channel (out)       source input (0/1) of the current out beat
//
// Optional feature, enabled by defining DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN:
//   clr_cnt (in)            zeroes both packet counters (wins over increment)
//   pkt_cnt0/pkt_cnt1 (out) per-input count of accepted EOP beats, wrapping
// -----------------------------------------------------------------------------
module de2_115_sopc_st_packet_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ERROR_WIDTH = 6,
    parameter int EMPTY_WIDTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,

    output logic                   in0_ready,
    input  logic                   in0_valid,
    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic [ERROR_WIDTH-1:0] in0_error,
    input  logic                   in0_startofpacket,
    input  logic                   in0_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in0_empty,

    output logic                   in1_ready,
    input  logic                   in1_valid,
    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic [ERROR_WIDTH-1:0] in1_error,
    input  logic                   in1_startofpacket,
    input  logic                   in1_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in1_empty,

    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [ERROR_WIDTH-1:0] out_error,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_channel
`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
    ,
    input  logic                   clr_cnt,
    output logic [CNT_WIDTH-1:0]   pkt_cnt0,
    output logic [CNT_WIDTH-1:0]   pkt_cnt1
`endif
);

    // Payload layout: {data, error, empty, sop, eop}; eop is bit 0.
    localparam int PW = DATA_WIDTH + ERROR_WIDTH + EMPTY_WIDTH + 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic            grant_reg, grant_next;
    logic            last_grant_reg, last_grant_next;

    logic            out_valid_reg;
    logic [PW-1:0]   out_payload_reg;
    logic            out_channel_reg;

    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [PW-1:0]   in_payload [2];
    logic            can_load;
    logic            sel;
    logic            xfer;
    logic            xfer_eop;

    assign in_valid      = {in1_valid, in0_valid};
    assign in_payload[0] = {in0_data, in0_error, in0_empty, in0_startofpacket, in0_endofpacket};
    assign in_payload[1] = {in1_data, in1_error, in1_empty, in1_startofpacket, in1_endofpacket};
    assign in0_ready     = in_ready[0];
    assign in1_ready     = in_ready[1];

    // The output stage can take a new beat when empty or draining this cycle.
    assign can_load = !out_valid_reg || out_ready;

    // Next-state / ready logic. Arbitration only happens in IDLE, so a packet
    // following an EOP can at the earliest start on the next cycle.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        sel             = grant_reg;
        in_ready        = '0;

        case (state_reg)
            IDLE: begin
                if (in_valid == 2'b11) begin
                    sel = ~last_grant_reg;
                end else begin
                    sel = in_valid[1];
                end
                if (in_valid != 2'b00) begin
                    in_ready[sel] = can_load;
                end
            end
            BUSY: begin
                in_ready[grant_reg] = can_load;
            end
            default: begin
                in_ready = '0;
            end
        endcase

        xfer     = in_valid[sel] && in_ready[sel];
        xfer_eop = xfer && in_payload[sel][0];

        if (xfer) begin
            if (xfer_eop) begin
                state_next      = IDLE;
                last_grant_next = sel;
            end else begin
                state_next = BUSY;
                grant_next = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;   // input 0 wins the first contention
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg   <= 1'b0;
            out_payload_reg <= '0;
            out_channel_reg <= 1'b0;
        end else if (xfer) begin
            out_valid_reg   <= 1'b1;
            out_payload_reg <= in_payload[sel];
            out_channel_reg <= sel;
        end else if (out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_channel = out_channel_reg;
    assign {out_data, out_error, out_empty, out_startofpacket, out_endofpacket} = out_payload_reg;

`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_pkt_cnt
        logic [CNT_WIDTH-1:0] cnt_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_reg <= '0;
            end else if (clr_cnt) begin
                cnt_reg <= '0;
            end else if (xfer_eop && (sel == 1'(gi))) begin
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign pkt_cnt0 = g_pkt_cnt[0].cnt_reg;
    assign pkt_cnt1 = g_pkt_cnt[1].cnt_reg;
`else
    // CNT_WIDTH only sizes the counters; this empty block merely consumes it
    // so the counter-less build has no dangling parameter.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_de2_115_sopc_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for de2_115_sopc_st_packet_arbiter.
// Directed scenarios followed by randomized traffic. A packet-level reference
// model (current owner, last winner, one-entry output stage) predicts readies
// and the registered output every cycle; captured output beat sequences are
// also compared against constant expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_de2_115_sopc_st_packet_arbiter;

    localparam int DW = 32;
    localparam int EW = 6;
    localparam int MW = 2;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] err;
        logic [MW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in0_ready, in1_ready;
    logic          in0_valid, in1_valid;
    logic [DW-1:0] in0_data, in1_data;
    logic [EW-1:0] in0_error, in1_error;
    logic          in0_startofpacket, in1_startofpacket;
    logic          in0_endofpacket, in1_endofpacket;
    logic [MW-1:0] in0_empty, in1_empty;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_error;
    logic          out_startofpacket, out_endofpacket;
    logic [MW-1:0] out_empty;
    logic          out_channel;
`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
    logic          clr_cnt;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

    always #5 clk = ~clk;

    de2_115_sopc_st_packet_arbiter #(
        .DATA_WIDTH(DW), .ERROR_WIDTH(EW), .EMPTY_WIDTH(MW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_ready(in0_ready), .in0_valid(in0_valid), .in0_data(in0_data),
        .in0_error(in0_error), .in0_startofpacket(in0_startofpacket),
        .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
        .in1_ready(in1_ready), .in1_valid(in1_valid), .in1_data(in1_data),
        .in1_error(in1_error), .in1_startofpacket(in1_startofpacket),
        .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_error(out_error), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket), .out_empty(out_empty),
        .out_channel(out_channel)
`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
        , .clr_cnt(clr_cnt), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    // Stimulus: pending beats per source, and whether each source drives valid.
    beat_t q0[$];
    beat_t q1[$];
    bit    en0, en1;

    // Captured output beats (accepted by downstream) for sequence checks.
    beat_t obs_b[$];
    bit    obs_c[$];

    // Reference model: owner = -1 when no packet is in flight.
    bit    m_ov;
    beat_t m_out;
    bit    m_ch;
    int    m_owner;
    int    m_last;
    int    m_cnt [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ov     = 1'b0;
        m_out    = '0;
        m_ch     = 1'b0;
        m_owner  = -1;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic drive_inputs();
        beat_t b0, b1;
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b1 = (q1.size() > 0) ? q1[0] : '0;
        in0_valid = en0 && (q0.size() > 0);
        in1_valid = en1 && (q1.size() > 0);
        {in0_data, in0_error, in0_empty, in0_startofpacket, in0_endofpacket} = b0;
        {in1_data, in1_error, in1_empty, in1_startofpacket, in1_endofpacket} = b1;
    endtask

    task automatic add_beat(int src, logic [DW-1:0] d, logic [EW-1:0] e,
                            logic [MW-1:0] m, bit s, bit p);
        beat_t b;
        b.data = d; b.err = e; b.empty = m; b.sop = s; b.eop = p;
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic add_pkt(int src, int len, logic [DW-1:0] base);
        for (int i = 0; i < len; i++)
            add_beat(src, base + DW'(i), EW'($urandom), MW'($urandom), i == 0, i == len - 1);
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance the
    // model for the coming rising edge, return 1 ns after it.
    task automatic step();
        bit    can, r0, r1, x0, x1;
        int    pick;
        beat_t b;
        drive_inputs();
        @(negedge clk);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_out.data);
        chk("out_error", out_error, m_out.err);
        chk("out_empty", out_empty, m_out.empty);
        chk("out_sop", out_startofpacket, m_out.sop);
        chk("out_eop", out_endofpacket, m_out.eop);
        chk("out_channel", out_channel, m_ch);
`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
        chk("pkt_cnt0", pkt_cnt0, m_cnt[0]);
        chk("pkt_cnt1", pkt_cnt1, m_cnt[1]);
`endif
        if (out_valid && out_ready) begin
            obs_b.push_back({out_data, out_error, out_empty, out_startofpacket, out_endofpacket});
            obs_c.push_back(out_channel);
        end

        can  = !m_ov || out_ready;
        pick = -1;
        if (m_owner >= 0)                 pick = m_owner;
        else if (in0_valid && in1_valid)  pick = 1 - m_last;
        else if (in0_valid)               pick = 0;
        else if (in1_valid)               pick = 1;
        r0 = (pick == 0) && can;
        r1 = (pick == 1) && can;
        chk("in0_ready", in0_ready, r0);
        chk("in1_ready", in1_ready, r1);

        x0 = in0_valid && r0;
        x1 = in1_valid && r1;
        if (x0 || x1) begin
            if (x0) b = q0.pop_front();
            else    b = q1.pop_front();
            m_out = b;
            m_ch  = x1;
            m_ov  = 1'b1;
            if (b.eop) begin
                m_owner = -1;
                m_last  = x1 ? 1 : 0;
            end else begin
                m_owner = x1 ? 1 : 0;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end

`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
        if (clr_cnt) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if ((x0 || x1) && b.eop) begin
            m_cnt[x1 ? 1 : 0] = (m_cnt[x1 ? 1 : 0] + 1) % (1 << CW);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        en0       = 1'b0;
        en1       = 1'b0;
        out_ready = 1'b1;
`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        q0.delete();
        q1.delete();
        obs_b.delete();
        obs_c.delete();
        drive_inputs();
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_eop", out_endofpacket, 1'b0);
        chk("rst_out_channel", out_channel, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int bound);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_ov) && n < bound) begin
            step();
            n++;
        end
        chk("drain_left", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_obs(int i, logic [DW-1:0] d, bit c);
        if (i < obs_b.size()) begin
            chk($sformatf("seq[%0d].data", i), obs_b[i].data, d);
            chk($sformatf("seq[%0d].chan", i), obs_c[i], c);
        end else begin
            chk($sformatf("seq[%0d].present", i), obs_b.size(), i + 1);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_d [8];
        bit            exp_c [8];

        #2;
        do_reset();

        // 1: single 3-beat packet from in0.
        add_beat(0, 32'h11, 6'h0, 2'd0, 1, 0);
        add_beat(0, 32'h22, 6'h0, 2'd0, 0, 0);
        add_beat(0, 32'h33, 6'h0, 2'd0, 0, 1);
        en0 = 1;
        drain(20);
        chk("p1_count", obs_b.size(), 3);
        chk_obs(0, 32'h11, 0);
        chk_obs(1, 32'h22, 0);
        chk_obs(2, 32'h33, 0);
        if (obs_b.size() == 3) begin
            chk("p1_sop_first", obs_b[0].sop, 1'b1);
            chk("p1_eop_last", obs_b[2].eop, 1'b1);
        end

        // 2: both inputs contend with 2-beat packets; strict alternation.
        do_reset();
        add_pkt(0, 2, 32'hA0); add_pkt(1, 2, 32'hB0);
        add_pkt(0, 2, 32'hA2); add_pkt(1, 2, 32'hB2);
        en0 = 1; en1 = 1;
        drain(40);
        exp_d = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};
        exp_c = '{0, 0, 1, 1, 0, 0, 1, 1};
        chk("p2_count", obs_b.size(), 8);
        for (int i = 0; i < 8; i++) chk_obs(i, exp_d[i], exp_c[i]);

        // 3: single-beat packet from in1 with empty=2.
        obs_b.delete(); obs_c.delete();
        en0 = 0; en1 = 1;
        add_beat(1, 32'hA5, 6'h0, 2'd2, 1, 1);
        drain(10);
        chk("p3_count", obs_b.size(), 1);
        chk_obs(0, 32'hA5, 1);
        if (obs_b.size() == 1) chk("p3_empty", obs_b[0].empty, 2'd2);

        // 4: downstream stall of 4 cycles mid-packet.
        do_reset();
        add_pkt(0, 4, 32'hC0);
        add_pkt(1, 2, 32'hD0);
        en0 = 1; en1 = 1;
        step(); step();
        out_ready = 0;
        repeat (4) step();
        out_ready = 1;
        drain(30);
        exp_d[0:5] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1};
        chk("p4_count", obs_b.size(), 6);
        for (int i = 0; i < 6; i++) chk_obs(i, exp_d[i], i >= 4);

        // 5: granted in0 drops valid mid-packet while in1 waits.
        do_reset();
        add_pkt(0, 3, 32'hE0);
        add_pkt(1, 2, 32'hF0);
        en0 = 1; en1 = 1;
        step();
        en0 = 0;
        repeat (3) step();
        en0 = 1;
        drain(30);
        exp_d[0:4] = '{32'hE0, 32'hE1, 32'hE2, 32'hF0, 32'hF1};
        chk("p5_count", obs_b.size(), 5);
        for (int i = 0; i < 5; i++) chk_obs(i, exp_d[i], i >= 3);

        // 6: randomized traffic, gaps and back-pressure.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (q0.size() < 3) add_pkt(0, int'($urandom_range(1, 4)), $urandom);
            if (q1.size() < 3) add_pkt(1, int'($urandom_range(1, 4)), $urandom);
            en0       = ($urandom_range(0, 3) != 0);
            en1       = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        en0 = 1; en1 = 1; out_ready = 1;
        drain(200);

        // 7: reset mid-packet drops the partial packet.
        do_reset();
        add_pkt(0, 4, 32'h70);
        en0 = 1;
        step(); step();
        do_reset();
        en1 = 1;
        add_beat(1, 32'h99, 6'h3, 2'd1, 1, 1);
        drain(10);
        chk("p7_count", obs_b.size(), 1);
        chk_obs(0, 32'h99, 1);

`ifdef DE2_115_SOPC_ST_PACKET_ARBITER_PKT_CNT_EN
        // 8: counter saturation/wrap and clear priority.
        do_reset();
        en0 = 1;
        for (int i = 0; i < 65535; i++) begin
            add_beat(0, DW'(i), 6'h0, 2'd0, 1, 1);
            step();
        end
        chk("pkt_cnt0_full", pkt_cnt0, 16'hFFFF);
        add_beat(0, 32'h1, 6'h0, 2'd0, 1, 1);
        step();
        chk("pkt_cnt0_wrap", pkt_cnt0, 16'h0000);
        add_beat(0, 32'h2, 6'h0, 2'd0, 1, 1);
        step();
        chk("pkt_cnt0_one", pkt_cnt0, 16'h0001);
        add_beat(0, 32'h3, 6'h0, 2'd0, 1, 1);
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        chk("pkt_cnt0_clr", pkt_cnt0, 16'h0000);
        chk("pkt_cnt1_clr", pkt_cnt1, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
